// File: rtl/proc_pkg.sv
// Shared types and constants for the multi-cycle processor controller.
package proc_pkg;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD_A = 4'd3,
    S_LOAD_B = 4'd4,
    S_STORE  = 4'd5,
    S_ADD    = 4'd6,
    S_SUB    = 4'd7,
    S_NOOP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  localparam logic RF_SEL_ALU = 1'b0;
  localparam logic RF_SEL_MEM = 1'b1;

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath/ROM bundle: instruction fetch plus all datapath control lines.
interface control_unit_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_data;
  logic [7:0]         D_addr;
  logic               D_wr;
  logic               RF_sel;
  logic [3:0]         WriteAddr;
  logic [3:0]         rdAddrA;
  logic [3:0]         rdAddrB;
  logic               RF_W_en;
  logic [2:0]         ALU_s0;

  modport master (
    output instr_addr, D_addr, D_wr, RF_sel, WriteAddr, rdAddrA, rdAddrB, RF_W_en, ALU_s0,
    input  instr_data
  );

  modport slave (
    input  instr_addr, D_addr, D_wr, RF_sel, WriteAddr, rdAddrA, rdAddrB, RF_W_en, ALU_s0,
    output instr_data
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter: synchronous clear / increment, natural wrap at 2**PC_W.
module pc_reg #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clr_i)      pc_d = '0;
    else if (inc_i) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FSM sequencing the 16-bit datapath: fetch, decode, execute until HALT.
module control_unit
  import proc_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  control_unit_if.master   bus,
  output logic             halted,
  output logic [3:0]       state_o,
  output logic [PC_W-1:0]  pc_o
);

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    pc;
  logic               pc_clr, pc_inc;
  logic               d_wr, rf_we;
  logic [2:0]         alu_sel;
  logic [3:0]         ir_op;

  pc_reg #(.PC_W(PC_W)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (pc_clr),
    .inc_i (pc_inc),
    .pc_o  (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) ir_q <= bus.instr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    d_wr    = 1'b0;
    rf_we   = 1'b0;
    alu_sel = ALU_PASS;
    unique case (state_q)
      S_INIT: begin
        pc_clr  = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        pc_inc = 1'b1;
        // ROM word is valid here, so branch on it directly rather than on IR.
        case (bus.instr_data[INSTR_W-1 -: 4])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_STORE: begin
        d_wr    = 1'b1;
        state_d = S_FETCH;
      end
      S_ADD: begin
        alu_sel = ALU_ADD;
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_SUB: begin
        alu_sel = ALU_SUB;
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_NOOP:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  // Addresses follow IR in every state; only enables and ALU select are state-gated.
  assign ir_op         = ir_q[INSTR_W-1 -: 4];
  assign bus.D_addr    = (ir_op == OP_STORE) ? ir_q[7:0] : ir_q[11:4];
  assign bus.RF_sel    = (ir_op == OP_LOAD) ? RF_SEL_MEM : RF_SEL_ALU;
  assign bus.rdAddrA   = ir_q[11:8];
  assign bus.rdAddrB   = ir_q[7:4];
  assign bus.WriteAddr = ir_q[3:0];
  assign bus.D_wr      = d_wr;
  assign bus.RF_W_en   = rf_we;
  assign bus.ALU_s0    = alu_sel;
  assign bus.instr_addr = pc;

  assign halted  = (state_q == S_HALT);
  assign state_o = state_q;
  assign pc_o    = pc;

endmodule

// File: tb/tb_control_unit.sv
// Bench: drives control_unit with a ROM + register file + data memory and checks against an ISA-level model.
module tb_control_unit;
  import proc_pkg::*;

  logic       clk, rst_n;
  logic       halted;
  logic [3:0] state_o;
  logic [6:0] pc_o;

  control_unit_if #(.PC_W(7), .INSTR_W(16)) bus ();

  control_unit #(.PC_W(7), .INSTR_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .halted  (halted),
    .state_o (state_o),
    .pc_o    (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side ROM and datapath
  logic [15:0] rom [128];
  logic [15:0] rf [16], dm [256], pre_rf [16], pre_dm [256];
  logic        pre_en;
  logic [15:0] alu_y;

  always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

  always_comb begin
    alu_y = rf[bus.rdAddrA];
    if (bus.ALU_s0 == 3'd1)      alu_y = rf[bus.rdAddrA] + rf[bus.rdAddrB];
    else if (bus.ALU_s0 == 3'd2) alu_y = rf[bus.rdAddrA] - rf[bus.rdAddrB];
  end

  always @(posedge clk) begin
    if (pre_en) begin
      rf <= pre_rf;
      dm <= pre_dm;
    end else begin
      if (bus.D_wr)    dm[bus.D_addr] <= rf[bus.rdAddrA];
      if (bus.RF_W_en) rf[bus.WriteAddr] <= bus.RF_sel ? dm[bus.D_addr] : alu_y;
    end
  end

  int we_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (bus.RF_W_en) we_cnt <= we_cnt + 1;
    if (bus.RF_W_en && bus.D_wr) both_cnt <= both_cnt + 1;
  end

  // ISA-level reference state
  logic [15:0] m_rf [16], m_dm [256];
  logic [6:0]  m_pc;
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_exec(input logic [15:0] ins);
    case (ins[15:12])
      4'd1: m_dm[ins[7:0]] = m_rf[ins[11:8]];
      4'd2: m_rf[ins[3:0]] = m_dm[ins[11:4]];
      4'd3: m_rf[ins[3:0]] = m_rf[ins[11:8]] + m_rf[ins[7:4]];
      4'd4: m_rf[ins[3:0]] = m_rf[ins[11:8]] - m_rf[ins[7:4]];
      default: ;
    endcase
    m_pc = m_pc + 7'd1;
  endtask

  task automatic cmp_arch(input string tag);
    int mism = 0;
    for (int i = 0; i < 16; i++)  if (rf[i] !== m_rf[i]) mism++;
    for (int i = 0; i < 256; i++) if (dm[i] !== m_dm[i]) mism++;
    chk(tag, mism, 0);
  endtask

  task automatic do_reset(input bit preload);
    rst_n = 1'b0;
    #1;
    chk("rst_state", state_o, S_INIT);
    chk("rst_en", {bus.D_wr, bus.RF_W_en, bus.RF_sel, halted}, 0);
    chk("rst_alu", bus.ALU_s0, 0);
    chk("rst_pc", pc_o, 0);
    pre_en = preload;
    step();
    step();
    pre_en = 1'b0;
    if (preload) begin
      m_rf = pre_rf;
      m_dm = pre_dm;
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_en", {bus.D_wr, bus.RF_W_en}, 0);
    step();
    chk("first_fetch", state_o, S_FETCH);
    m_pc = 7'd0;
  endtask

  // Runs one instruction from its FETCH cycle and checks controls, latency and architectural state.
  task automatic exec_one(input string tag);
    logic [15:0] ins;
    logic [3:0]  op;
    int cyc = 0, nwr = 0, nwe = 0, lat;
    logic [7:0] da [8];
    logic       we [8], rs [8];
    logic [2:0] al [8];
    logic [3:0] wa [8], ra [8], rb [8];
    ins = rom[m_pc];
    op  = ins[15:12];
    chk({tag, "_pc"}, pc_o, m_pc);
    while (cyc < 8) begin
      da[cyc] = bus.D_addr;  we[cyc] = bus.RF_W_en; rs[cyc] = bus.RF_sel;
      al[cyc] = bus.ALU_s0;  wa[cyc] = bus.WriteAddr;
      ra[cyc] = bus.rdAddrA; rb[cyc] = bus.rdAddrB;
      nwr += int'(bus.D_wr);
      nwe += int'(bus.RF_W_en);
      step();
      cyc++;
      if (state_o == S_FETCH || halted) break;
    end
    lat = (op == 4'd2) ? 4 : (op == 4'd5) ? 2 : 3;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_nwe"}, nwe, (op >= 4'd2 && op <= 4'd4) ? 1 : 0);
    chk({tag, "_nwr"}, nwr, (op == 4'd1) ? 1 : 0);
    case (op)
      4'd1: chk({tag, "_st"}, {da[2], ra[2]}, {ins[7:0], ins[11:8]});
      4'd2: begin
        chk({tag, "_la"}, {da[2], we[2], rs[2]}, {ins[11:4], 1'b0, 1'b1});
        chk({tag, "_lb"}, {da[3], we[3], rs[3], wa[3]}, {ins[11:4], 1'b1, 1'b1, ins[3:0]});
      end
      4'd3, 4'd4: chk({tag, "_alu"}, {al[2], ra[2], rb[2], wa[2], rs[2]},
                      {(op == 4'd3) ? 3'd1 : 3'd2, ins[11:8], ins[7:4], ins[3:0], 1'b0});
      4'd5: chk({tag, "_halt"}, halted, 1'b1);
      default: ;
    endcase
    ref_exec(ins);
    cmp_arch({tag, "_arch"});
  endtask

  task automatic clear_pre();
    for (int i = 0; i < 16; i++)  pre_rf[i] = 16'h0;
    for (int i = 0; i < 256; i++) pre_dm[i] = 16'h0;
  endtask

  initial begin
    int we_snap;
    logic [3:0] op;
    rst_n  = 1'b0;
    pre_en = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0;
    clear_pre();
    step();

    // Directed program: LOAD, ADD, SUB, STORE, SUB underflow, HALT
    pre_rf[0] = 16'h3333; pre_rf[2] = 16'h2222; pre_rf[4] = 16'h0000; pre_rf[5] = 16'h0001;
    pre_dm[8'h01] = 16'h1111;
    rom[0] = 16'h2011; rom[1] = 16'h3123; rom[2] = 16'h4021;
    rom[3] = 16'h116A; rom[4] = 16'h4456; rom[5] = 16'h5000;
    do_reset(1'b1);
    exec_one("load");  chk("load_rf1", rf[1], 16'h1111);
    exec_one("add");   chk("add_rf3", rf[3], 16'h3333);
    exec_one("sub");   chk("sub_rf1", rf[1], 16'h1111);
    exec_one("store"); chk("store_dm6a", dm[8'h6A], 16'h1111);
    exec_one("subw");  chk("sub_wrap", rf[6], 16'hFFFF);
    exec_one("halt");
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt_hold", {halted, pc_o, bus.D_wr, bus.RF_W_en}, {1'b1, 7'd6, 1'b0, 1'b0});
    end

    // Reset during LOAD_A must abort the write
    clear_pre();
    pre_dm[8'h01] = 16'hABCD;
    rom[0] = 16'h2011;
    do_reset(1'b1);
    step();
    step();
    chk("mid_load_state", state_o, S_LOAD_A);
    we_snap = we_cnt;
    rst_n = 1'b0;
    rom[0] = 16'h0000;
    #1;
    chk("abort_state", {state_o, bus.RF_W_en}, {S_INIT, 1'b0});
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("restart_fetch", {state_o, pc_o}, {S_FETCH, 7'd0});
    chk("abort_rf1", rf[1], 16'h0000);
    chk("abort_we", we_cnt, we_snap);
    m_pc = 7'd0;
    exec_one("restart");

    // PC wrap with a ROM of NOOPs (both opcode 0 and undefined opcodes)
    for (int i = 0; i < 128; i++) begin
      op = 4'($urandom_range(0, 10));
      if (op != 4'd0) op = op + 4'd5;
      rom[i] = {op, 12'($urandom)};
    end
    do_reset(1'b1);
    for (int i = 0; i < 128; i++) exec_one("noop");
    chk("pc_wrap", pc_o, 0);

    // Randomized programs against the ISA model
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++)  pre_rf[i] = 16'($urandom);
      for (int i = 0; i < 256; i++) pre_dm[i] = 16'($urandom);
      for (int i = 0; i < 128; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd5) op = 4'd3;
        rom[i] = {op, 12'($urandom)};
      end
      do_reset(1'b1);
      for (int i = 0; i < 50; i++) exec_one("rand");
    end

    chk("no_dual_enable", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
